ysyx_041461_pipe_stage: RTL and testbench

//   Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with valid/ready handshake.
//   Two-entry skid buffer: in_ready is a pure register output, so no combinational ready path crosses stages.

---
 rtl/ysyx_041461_pipe_stage_pkg.sv | 27 ++
 rtl/ysyx_041461_macro.v | 13 +
 rtl/ysyx_041461_perf_cnt.sv | 30 +++
 rtl/ysyx_041461_pipe_stage.sv | 118 +++++++++++
 tb/tb_ysyx_041461_pipe_stage.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_041461_pipe_stage_pkg.sv
// rtl/ysyx_041461_pipe_stage_pkg.sv - pipe-stage state type and perf width
// The encodings mirror ysyx_041461_macro.v; the guards keep this file usable
// whether or not the macro file was read first.
`ifndef ysyx_041461_PS_EMPTY
`define ysyx_041461_PS_EMPTY 2'b00
`endif
`ifndef ysyx_041461_PS_BUSY
`define ysyx_041461_PS_BUSY 2'b01
`endif
`ifndef ysyx_041461_PS_FULL
`define ysyx_041461_PS_FULL 2'b10
`endif
`ifndef ysyx_041461_PERF_W
`define ysyx_041461_PERF_W 32
`endif

package ysyx_041461_pipe_stage_pkg;

  localparam int PERF_W = `ysyx_041461_PERF_W;

  typedef enum logic [1:0] {
    PS_EMPTY = `ysyx_041461_PS_EMPTY,
    PS_BUSY  = `ysyx_041461_PS_BUSY,
    PS_FULL  = `ysyx_041461_PS_FULL
  } ps_state_e;

endpackage

// File: rtl/ysyx_041461_macro.v
// rtl/ysyx_041461_macro.v - shared pipe-stage state encodings and perf counter width
`ifndef ysyx_041461_PS_EMPTY
`define ysyx_041461_PS_EMPTY 2'b00
`endif
`ifndef ysyx_041461_PS_BUSY
`define ysyx_041461_PS_BUSY 2'b01
`endif
`ifndef ysyx_041461_PS_FULL
`define ysyx_041461_PS_FULL 2'b10
`endif
`ifndef ysyx_041461_PERF_W
`define ysyx_041461_PERF_W 32
`endif

// File: rtl/ysyx_041461_perf_cnt.sv
// rtl/ysyx_041461_perf_cnt.sv - enable-gated wrapping event counter, async reset
module ysyx_041461_perf_cnt
  import ysyx_041461_pipe_stage_pkg::*;
#(
  parameter int W = PERF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Count one per enabled cycle; natural overflow wraps all-ones to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + 1'b1;
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ysyx_041461_pipe_stage.sv
// rtl/ysyx_041461_pipe_stage.sv - two-entry skid pipeline register; optional YSYX_041461_PIPE_PERF_EN
module ysyx_041461_pipe_stage
  import ysyx_041461_pipe_stage_pkg::*;
#(
  parameter int                DATA_W    = 96,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef YSYX_041461_PIPE_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall,
  output logic [PERF_W-1:0] perf_full
`endif
);

  ps_state_e         state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              in_fire;
  logic              out_fire;

  // Handshakes use only registered flags, so no ready path crosses stages.
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Next-state and payload steering; flush wins over everything and drops a
  // same-cycle input, payload registers simply hold.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = PS_EMPTY;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            state_d = PS_BUSY;
            main_d  = in_data;
          end
        end
        PS_BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = PS_FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = PS_EMPTY;
          end
        end
        PS_FULL: begin
          if (out_fire) begin
            state_d = PS_BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  // State and handshake flags; flags are precomputed from the next state so
  // in_ready/out_valid come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PS_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != PS_FULL);
      out_valid_q <= (state_d != PS_EMPTY);
    end
  end

  // Payload storage: main drives the output, skid absorbs one extra entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

`ifdef YSYX_041461_PIPE_PERF_EN
  ysyx_041461_perf_cnt #(.W(PERF_W)) u_perf_stall (
    .clk   (clk),
    .rst   (rst),
    .en_i  (out_valid_q & ~out_ready),
    .cnt_o (perf_stall)
  );

  ysyx_041461_perf_cnt #(.W(PERF_W)) u_perf_full (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q == PS_FULL),
    .cnt_o (perf_full)
  );
`endif

endmodule

// File: tb/tb_ysyx_041461_pipe_stage.sv
// tb/tb_ysyx_041461_pipe_stage.sv - scoreboard bench for ysyx_041461_pipe_stage
module tb_ysyx_041461_pipe_stage;

  localparam int              W  = 96;
  localparam logic [W-1:0]    RV = 96'h0000_0000_0000_0000_8000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef YSYX_041461_PIPE_PERF_EN
  logic [31:0]  perf_stall;
  logic [31:0]  perf_full;
`endif

  ysyx_041461_pipe_stage #(.DATA_W(W), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef YSYX_041461_PIPE_PERF_EN
    ,
    .perf_stall(perf_stall),
    .perf_full (perf_full)
`endif
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_shown;
  bit           mon_en = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of depth two that a flush empties.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_shown = RV;
    end else if (mon_en) begin
      bit model_ready;
      model_ready = (exp_q.size() < 2);
      chk("out_valid", out_valid, exp_q.size() > 0);
      chk("in_ready", in_ready, model_ready);
      if (exp_q.size() > 0) begin
        chk("out_data", out_data, exp_q[0]);
        last_shown = exp_q[0];
      end else begin
        chk("out_data_hold", out_data, last_shown);
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && model_ready) exp_q.push_back(in_data);
      end
    end
  end

  // Random upstream/downstream; upstream holds an offered entry until taken.
  task automatic step(input int vp, input int rp, input int fp);
    bit acc;
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (!in_valid || acc) begin
      in_valid = ($urandom_range(99) < vp);
      in_data  = {$urandom, $urandom, $urandom};
    end
    out_ready = ($urandom_range(99) < rp);
    flush     = ($urandom_range(99) < fp);
  endtask

  task automatic drive(input bit v, input logic [W-1:0] d, input bit r, input bit f);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    last_shown = RV;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_data", out_data, RV);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Streaming 1..8 with no bubbles
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0);
      @(negedge clk);
      if (i > 1) begin
        chk("stream_valid", out_valid, 1'b1);
        chk("stream_data", out_data, W'(i - 1));
      end
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("stream_last", out_data, W'(8));
    drive(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: A,B fill the stage, then drain in order
    drive(1'b1, W'('hA), 1'b0, 1'b0);
    drive(1'b1, W'('hB), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_full_ready", in_ready, 1'b0);
    chk("bp_full_data", out_data, W'('hA));
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_still_full", in_ready, 1'b0);
    @(negedge clk);
    chk("bp_ready_back", in_ready, 1'b1);
    chk("bp_second", out_data, W'('hB));
    @(negedge clk);
    chk("bp_drained", out_valid, 1'b0);

    // Flush while FULL with C offered
    drive(1'b1, W'('hD), 1'b0, 1'b0);
    drive(1'b1, W'('hE), 1'b0, 1'b0);
    drive(1'b1, W'('hC), 1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("flush_full_valid", out_valid, 1'b0);
    chk("flush_full_hold", out_data, W'('hD));

    // Flush while BUSY colliding with an accepted C
    drive(1'b1, W'('hF), 1'b0, 1'b0);
    drive(1'b1, W'('hC), 1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("flush_busy_no_c", out_valid, 1'b0);
    end

`ifdef YSYX_041461_PIPE_PERF_EN
    begin
      logic [31:0] s0, f0;
      drive(1'b1, W'('h11), 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      s0 = perf_stall;
      repeat (5) drive(1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      chk("perf_stall_5", perf_stall, s0 + 32'd5);
      drive(1'b1, W'('h12), 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      f0 = perf_full;
      repeat (3) drive(1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      chk("perf_full_3", perf_full, f0 + 32'd3);
      drive(1'b0, '0, 1'b1, 1'b1);
      @(negedge clk);
      chk("perf_flush_keeps", perf_full, f0 + 32'd4);
      drive(1'b0, '0, 1'b1, 1'b0);
    end
`endif

    // Random traffic with occasional flush
    for (int c = 0; c < 10000; c++) begin
      step(70, 65, 2);
    end

    // Asynchronous reset mid-stream
    in_valid = 1'b1; in_data = W'('h77); out_ready = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midreset_out_valid", out_valid, 1'b0);
    chk("midreset_in_ready", in_ready, 1'b1);
    chk("midreset_out_data", out_data, RV);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 300; c++) begin
      step(60, 60, 0);
    end

    // Drain and confirm nothing is left outstanding
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("final_empty", W'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
